// File: rtl/aes_pkg.sv
// Shared AES geometry, the InvSubBytes FSM encoding and a row extraction helper.
// Row r of a state occupies bits [127-32r -: 32], with column 0 in the top byte.
package aes_pkg;

    localparam int AES_ROW_W    = 32;
    localparam int AES_STATE_W  = 128;
    localparam int AES_NUM_ROWS = 4;

    typedef enum logic [1:0] {
        ISB_IDLE,
        ISB_BUSY,
        ISB_DONE
    } isb_state_t;

    function automatic logic [AES_ROW_W-1:0] row_of(input logic [AES_STATE_W-1:0] state,
                                                    input logic [1:0] r);
        return state[AES_STATE_W-1-AES_ROW_W*int'(r) -: AES_ROW_W];
    endfunction

endpackage

// File: rtl/inv_s_box.sv
// Combinational inverse AES S-box applied to the four bytes of one 32-bit row.
module inv_s_box
    import aes_pkg::*;
(
    input  logic [AES_ROW_W-1:0] row_in,
    output logic [AES_ROW_W-1:0] row_out
);

    function automatic logic [7:0] inv_byte(input logic [7:0] x);
        logic [7:0] b;
        case (x)
            8'h00: b = 8'h52; 8'h01: b = 8'h09; 8'h02: b = 8'h6a; 8'h03: b = 8'hd5;
            8'h04: b = 8'h30; 8'h05: b = 8'h36; 8'h06: b = 8'ha5; 8'h07: b = 8'h38;
            8'h08: b = 8'hbf; 8'h09: b = 8'h40; 8'h0a: b = 8'ha3; 8'h0b: b = 8'h9e;
            8'h0c: b = 8'h81; 8'h0d: b = 8'hf3; 8'h0e: b = 8'hd7; 8'h0f: b = 8'hfb;
            8'h10: b = 8'h7c; 8'h11: b = 8'he3; 8'h12: b = 8'h39; 8'h13: b = 8'h82;
            8'h14: b = 8'h9b; 8'h15: b = 8'h2f; 8'h16: b = 8'hff; 8'h17: b = 8'h87;
            8'h18: b = 8'h34; 8'h19: b = 8'h8e; 8'h1a: b = 8'h43; 8'h1b: b = 8'h44;
            8'h1c: b = 8'hc4; 8'h1d: b = 8'hde; 8'h1e: b = 8'he9; 8'h1f: b = 8'hcb;
            8'h20: b = 8'h54; 8'h21: b = 8'h7b; 8'h22: b = 8'h94; 8'h23: b = 8'h32;
            8'h24: b = 8'ha6; 8'h25: b = 8'hc2; 8'h26: b = 8'h23; 8'h27: b = 8'h3d;
            8'h28: b = 8'hee; 8'h29: b = 8'h4c; 8'h2a: b = 8'h95; 8'h2b: b = 8'h0b;
            8'h2c: b = 8'h42; 8'h2d: b = 8'hfa; 8'h2e: b = 8'hc3; 8'h2f: b = 8'h4e;
            8'h30: b = 8'h08; 8'h31: b = 8'h2e; 8'h32: b = 8'ha1; 8'h33: b = 8'h66;
            8'h34: b = 8'h28; 8'h35: b = 8'hd9; 8'h36: b = 8'h24; 8'h37: b = 8'hb2;
            8'h38: b = 8'h76; 8'h39: b = 8'h5b; 8'h3a: b = 8'ha2; 8'h3b: b = 8'h49;
            8'h3c: b = 8'h6d; 8'h3d: b = 8'h8b; 8'h3e: b = 8'hd1; 8'h3f: b = 8'h25;
            8'h40: b = 8'h72; 8'h41: b = 8'hf8; 8'h42: b = 8'hf6; 8'h43: b = 8'h64;
            8'h44: b = 8'h86; 8'h45: b = 8'h68; 8'h46: b = 8'h98; 8'h47: b = 8'h16;
            8'h48: b = 8'hd4; 8'h49: b = 8'ha4; 8'h4a: b = 8'h5c; 8'h4b: b = 8'hcc;
            8'h4c: b = 8'h5d; 8'h4d: b = 8'h65; 8'h4e: b = 8'hb6; 8'h4f: b = 8'h92;
            8'h50: b = 8'h6c; 8'h51: b = 8'h70; 8'h52: b = 8'h48; 8'h53: b = 8'h50;
            8'h54: b = 8'hfd; 8'h55: b = 8'hed; 8'h56: b = 8'hb9; 8'h57: b = 8'hda;
            8'h58: b = 8'h5e; 8'h59: b = 8'h15; 8'h5a: b = 8'h46; 8'h5b: b = 8'h57;
            8'h5c: b = 8'ha7; 8'h5d: b = 8'h8d; 8'h5e: b = 8'h9d; 8'h5f: b = 8'h84;
            8'h60: b = 8'h90; 8'h61: b = 8'hd8; 8'h62: b = 8'hab; 8'h63: b = 8'h00;
            8'h64: b = 8'h8c; 8'h65: b = 8'hbc; 8'h66: b = 8'hd3; 8'h67: b = 8'h0a;
            8'h68: b = 8'hf7; 8'h69: b = 8'he4; 8'h6a: b = 8'h58; 8'h6b: b = 8'h05;
            8'h6c: b = 8'hb8; 8'h6d: b = 8'hb3; 8'h6e: b = 8'h45; 8'h6f: b = 8'h06;
            8'h70: b = 8'hd0; 8'h71: b = 8'h2c; 8'h72: b = 8'h1e; 8'h73: b = 8'h8f;
            8'h74: b = 8'hca; 8'h75: b = 8'h3f; 8'h76: b = 8'h0f; 8'h77: b = 8'h02;
            8'h78: b = 8'hc1; 8'h79: b = 8'haf; 8'h7a: b = 8'hbd; 8'h7b: b = 8'h03;
            8'h7c: b = 8'h01; 8'h7d: b = 8'h13; 8'h7e: b = 8'h8a; 8'h7f: b = 8'h6b;
            8'h80: b = 8'h3a; 8'h81: b = 8'h91; 8'h82: b = 8'h11; 8'h83: b = 8'h41;
            8'h84: b = 8'h4f; 8'h85: b = 8'h67; 8'h86: b = 8'hdc; 8'h87: b = 8'hea;
            8'h88: b = 8'h97; 8'h89: b = 8'hf2; 8'h8a: b = 8'hcf; 8'h8b: b = 8'hce;
            8'h8c: b = 8'hf0; 8'h8d: b = 8'hb4; 8'h8e: b = 8'he6; 8'h8f: b = 8'h73;
            8'h90: b = 8'h96; 8'h91: b = 8'hac; 8'h92: b = 8'h74; 8'h93: b = 8'h22;
            8'h94: b = 8'he7; 8'h95: b = 8'had; 8'h96: b = 8'h35; 8'h97: b = 8'h85;
            8'h98: b = 8'he2; 8'h99: b = 8'hf9; 8'h9a: b = 8'h37; 8'h9b: b = 8'he8;
            8'h9c: b = 8'h1c; 8'h9d: b = 8'h75; 8'h9e: b = 8'hdf; 8'h9f: b = 8'h6e;
            8'ha0: b = 8'h47; 8'ha1: b = 8'hf1; 8'ha2: b = 8'h1a; 8'ha3: b = 8'h71;
            8'ha4: b = 8'h1d; 8'ha5: b = 8'h29; 8'ha6: b = 8'hc5; 8'ha7: b = 8'h89;
            8'ha8: b = 8'h6f; 8'ha9: b = 8'hb7; 8'haa: b = 8'h62; 8'hab: b = 8'h0e;
            8'hac: b = 8'haa; 8'had: b = 8'h18; 8'hae: b = 8'hbe; 8'haf: b = 8'h1b;
            8'hb0: b = 8'hfc; 8'hb1: b = 8'h56; 8'hb2: b = 8'h3e; 8'hb3: b = 8'h4b;
            8'hb4: b = 8'hc6; 8'hb5: b = 8'hd2; 8'hb6: b = 8'h79; 8'hb7: b = 8'h20;
            8'hb8: b = 8'h9a; 8'hb9: b = 8'hdb; 8'hba: b = 8'hc0; 8'hbb: b = 8'hfe;
            8'hbc: b = 8'h78; 8'hbd: b = 8'hcd; 8'hbe: b = 8'h5a; 8'hbf: b = 8'hf4;
            8'hc0: b = 8'h1f; 8'hc1: b = 8'hdd; 8'hc2: b = 8'ha8; 8'hc3: b = 8'h33;
            8'hc4: b = 8'h88; 8'hc5: b = 8'h07; 8'hc6: b = 8'hc7; 8'hc7: b = 8'h31;
            8'hc8: b = 8'hb1; 8'hc9: b = 8'h12; 8'hca: b = 8'h10; 8'hcb: b = 8'h59;
            8'hcc: b = 8'h27; 8'hcd: b = 8'h80; 8'hce: b = 8'hec; 8'hcf: b = 8'h5f;
            8'hd0: b = 8'h60; 8'hd1: b = 8'h51; 8'hd2: b = 8'h7f; 8'hd3: b = 8'ha9;
            8'hd4: b = 8'h19; 8'hd5: b = 8'hb5; 8'hd6: b = 8'h4a; 8'hd7: b = 8'h0d;
            8'hd8: b = 8'h2d; 8'hd9: b = 8'he5; 8'hda: b = 8'h7a; 8'hdb: b = 8'h9f;
            8'hdc: b = 8'h93; 8'hdd: b = 8'hc9; 8'hde: b = 8'h9c; 8'hdf: b = 8'hef;
            8'he0: b = 8'ha0; 8'he1: b = 8'he0; 8'he2: b = 8'h3b; 8'he3: b = 8'h4d;
            8'he4: b = 8'hae; 8'he5: b = 8'h2a; 8'he6: b = 8'hf5; 8'he7: b = 8'hb0;
            8'he8: b = 8'hc8; 8'he9: b = 8'heb; 8'hea: b = 8'hbb; 8'heb: b = 8'h3c;
            8'hec: b = 8'h83; 8'hed: b = 8'h53; 8'hee: b = 8'h99; 8'hef: b = 8'h61;
            8'hf0: b = 8'h17; 8'hf1: b = 8'h2b; 8'hf2: b = 8'h04; 8'hf3: b = 8'h7e;
            8'hf4: b = 8'hba; 8'hf5: b = 8'h77; 8'hf6: b = 8'hd6; 8'hf7: b = 8'h26;
            8'hf8: b = 8'he1; 8'hf9: b = 8'h69; 8'hfa: b = 8'h14; 8'hfb: b = 8'h63;
            8'hfc: b = 8'h55; 8'hfd: b = 8'h21; 8'hfe: b = 8'h0c; 8'hff: b = 8'h7d;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    for (genvar gi = 0; gi < AES_ROW_W / 8; gi++) begin : g_byte
        assign row_out[AES_ROW_W-1-8*gi -: 8] = inv_byte(row_in[AES_ROW_W-1-8*gi -: 8]);
    end

endmodule

// File: rtl/inv_sub_bytes_engine.sv
// Sequential AES InvSubBytes: substitutes ROWS_PER_CYCLE rows of a buffered state per clock,
// then presents the registered result until the downstream handshake.
module inv_sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] state_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] state_out,
    output logic                   busy
);

    if (ROWS_PER_CYCLE != 1 && ROWS_PER_CYCLE != 2 && ROWS_PER_CYCLE != 4) begin : g_bad_rpc
        $error("inv_sub_bytes_engine: ROWS_PER_CYCLE must be 1, 2 or 4");
    end

    // Row groups are aligned to ROWS_PER_CYCLE, so row_cnt never addresses past row 3.
    localparam logic [1:0] RPC_INC  = 2'(ROWS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(AES_NUM_ROWS - ROWS_PER_CYCLE);

    isb_state_t             state_q, state_d;
    logic [1:0]             row_cnt_q, row_cnt_d;
    logic [AES_STATE_W-1:0] buf_q, buf_d;
    logic [AES_STATE_W-1:0] state_out_q, state_out_d;

    logic [AES_ROW_W-1:0]   lookup_out [AES_NUM_ROWS];
    logic [AES_STATE_W-1:0] buf_subst;

    for (genvar gi = 0; gi < AES_NUM_ROWS; gi++) begin : g_lookup
        if (gi < ROWS_PER_CYCLE) begin : g_inst
            inv_s_box u_inv_s_box (
                .row_in  (row_of(buf_q, row_cnt_q + 2'(gi))),
                .row_out (lookup_out[gi])
            );
        end else begin : g_unused
            assign lookup_out[gi] = '0;
        end
    end

    // Each buffer row takes the lookup lane whose offset from row_cnt matches, else holds.
    for (genvar gi = 0; gi < AES_NUM_ROWS; gi++) begin : g_row
        logic [1:0] off;
        assign off = 2'(gi) - row_cnt_q;
        assign buf_subst[AES_STATE_W-1-AES_ROW_W*gi -: AES_ROW_W] =
            (int'(off) < ROWS_PER_CYCLE) ? lookup_out[off] : row_of(buf_q, 2'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ISB_IDLE;
            row_cnt_q   <= '0;
            buf_q       <= '0;
            state_out_q <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            buf_q       <= buf_d;
            state_out_q <= state_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        buf_d       = buf_q;
        state_out_d = state_out_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (state_q)
            ISB_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_d     = state_in;
                    row_cnt_d = '0;
                    state_d   = ISB_BUSY;
                end
            end
            ISB_BUSY: begin
                busy      = 1'b1;
                buf_d     = buf_subst;
                row_cnt_d = row_cnt_q + RPC_INC;
                if (row_cnt_q == LAST_CNT) begin
                    state_out_d = buf_subst;
                    state_d     = ISB_DONE;
                end
            end
            ISB_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ISB_IDLE;
                end
            end
            default: state_d = ISB_IDLE;
        endcase
    end

    assign state_out = state_out_q;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Scoreboard bench: three engines (1, 2 and 4 rows per cycle); stimulus pushes expected
// results and timed status probes, one monitor pops and compares them.
module tb_inv_sub_bytes_engine;

    logic         clk = 1'b0;
    logic         rst       [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] state_in  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] state_out [3];
    logic         busy      [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        inv_sub_bytes_engine #(.ROWS_PER_CYCLE(1 << gi)) u_dut (
            .clk       (clk),
            .rst       (rst[gi]),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .state_in  (state_in[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .state_out (state_out[gi]),
            .busy      (busy[gi])
        );
    end

    typedef struct {
        int           dut;
        logic [127:0] data;
        int           acc;
        int           lat;
    } exp_t;

    typedef struct {
        int           dut;
        int           cyc;
        logic [2:0]   flags;      // {in_ready, out_valid, busy}
        logic         chk_state;
        logic [127:0] st;
    } probe_t;

    exp_t   exp_q[$];
    probe_t probe_q[$];
    int     cyc = 0;
    int     errors = 0;
    int     checks = 0;
    logic   prev_valid [3] = '{1'b0, 1'b0, 1'b0};

    // Forward AES S-box, used only to build inputs whose inverse is the byte index.
    logic [7:0] fwd [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [127:0] KV_IN  = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
    localparam logic [127:0] KV_OUT = 128'h00010203_04050607_08090a0b_0c0d0e0f;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs against the scoreboard, then any probes due this cycle.
    always @(negedge clk) begin
        probe_t p;
        for (int k = 0; k < 3; k++) begin
            if (out_valid[k]) begin
                if (exp_q.size() == 0 || exp_q[0].dut != k) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out dut%0d cyc=%0d got out_valid=1 state_out=%h, required no output",
                             k, cyc, state_out[k]);
                end else begin
                    if (!prev_valid[k]) begin
                        checks++;
                        if (cyc - exp_q[0].acc != exp_q[0].lat) begin
                            errors++;
                            $display("FAIL latency dut%0d got %0d required %0d",
                                     k, cyc - exp_q[0].acc, exp_q[0].lat);
                        end
                    end
                    checks++;
                    if (state_out[k] !== exp_q[0].data) begin
                        errors++;
                        $display("FAIL data dut%0d cyc=%0d got %h required %h",
                                 k, cyc, state_out[k], exp_q[0].data);
                    end
                    checks++;
                    if ({in_ready[k], busy[k]} !== 2'b01) begin
                        errors++;
                        $display("FAIL done_flags dut%0d got {in_ready,busy}=%b required 01",
                                 k, {in_ready[k], busy[k]});
                    end
                    if (out_ready[k]) begin
                        $display("dut%0d cyc=%0d result %h", k, cyc, state_out[k]);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_valid[k] = out_valid[k];
        end
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            p = probe_q.pop_front();
            checks++;
            if (p.cyc != cyc) begin
                errors++;
                $display("FAIL probe_missed dut%0d got cyc=%0d required %0d", p.dut, cyc, p.cyc);
            end else if ({in_ready[p.dut], out_valid[p.dut], busy[p.dut]} !== p.flags) begin
                errors++;
                $display("FAIL probe_flags dut%0d cyc=%0d got {in_ready,out_valid,busy}=%b required %b",
                         p.dut, cyc, {in_ready[p.dut], out_valid[p.dut], busy[p.dut]}, p.flags);
            end else if (p.chk_state && state_out[p.dut] !== p.st) begin
                errors++;
                $display("FAIL probe_state dut%0d cyc=%0d got %h required %h",
                         p.dut, cyc, state_out[p.dut], p.st);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic probe(input int k, input int at, input logic [2:0] flags,
                         input logic chk, input logic [127:0] st);
        probe_q.push_back('{dut: k, cyc: at, flags: flags, chk_state: chk, st: st});
    endtask

    // Returns one cycle after the accepting edge, i.e. with cyc equal to that edge.
    task automatic send(input int k, input logic [127:0] d, input logic [127:0] e, input bit keep);
        int t = 0;
        state_in[k] = d;
        in_valid[k] = 1'b1;
        while (!in_ready[k]) begin
            if (t >= 100) begin
                $display("FAIL accept_timeout dut%0d got in_ready=0 required 1 within 100 cycles", k);
                $fatal(1, "accept timeout");
            end
            step(1);
            t++;
        end
        exp_q.push_back('{dut: k, data: e, acc: cyc + 1, lat: 4 >> k});
        $display("dut%0d cyc=%0d accept %h expect %h", k, cyc + 1, d, e);
        step(1);
        if (!keep) in_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 || probe_q.size() != 0) begin
            if (t >= 200) begin
                $display("FAIL drain_timeout got %0d results %0d probes pending, required 0",
                         exp_q.size(), probe_q.size());
                $fatal(1, "drain timeout");
            end
            step(1);
            t++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got time=%0t required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        logic [127:0] e;
        int           e0;
        logic [127:0] b2b_in  [5];
        logic [127:0] b2b_out [5];

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b1; state_in[k] = '0;
        end
        step(3);
        for (int k = 0; k < 3; k++) probe(k, cyc, 3'b100, 1'b1, '0);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        step(1);

        // Known vector with BUSY status on each of the four substitution cycles.
        send(0, KV_IN, KV_OUT, 1'b0);
        e0 = cyc;
        for (int i = 0; i < 4; i++) probe(0, e0 + i, 3'b001, 1'b0, '0);
        drain();

        // Every byte value through all three widths.
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < 16; b++) begin
                for (int i = 0; i < 16; i++) begin
                    d[127-8*i -: 8] = fwd[16*b + i];
                    e[127-8*i -: 8] = 8'(16*b + i);
                end
                send(k, d, e, 1'b0);
            end
            drain();
        end

        // Backpressure: result held for 10+ cycles, then IDLE right after release.
        out_ready[0] = 1'b0;
        send(0, '0, {16{8'h52}}, 1'b0);
        step(14);
        out_ready[0] = 1'b1;
        probe(0, cyc + 1, 3'b100, 1'b1, {16{8'h52}});
        drain();

        // Inputs offered while busy or done are ignored until the handshake.
        out_ready[0] = 1'b0;
        send(0, KV_IN, KV_OUT, 1'b0);
        state_in[0] = {128{1'b1}};
        for (int i = 0; i < 8; i++) begin
            in_valid[0] = 1'(i % 2 == 0);
            step(1);
        end
        out_ready[0] = 1'b1;
        send(0, {128{1'b1}}, {16{8'h7d}}, 1'b0);
        drain();

        // Reset on the second BUSY cycle discards the block.
        send(0, KV_IN, KV_OUT, 1'b0);
        step(1);
        rst[0] = 1'b1;
        exp_q.delete();
        probe(0, cyc + 1, 3'b100, 1'b1, '0);
        step(1);
        rst[0] = 1'b0;
        send(0, {16{8'h63}}, '0, 1'b0);
        drain();

        // Back-to-back with in_valid and out_ready held high: one accept every 6 cycles.
        b2b_in[0] = KV_IN;                 b2b_out[0] = KV_OUT;
        b2b_in[1] = '0;                    b2b_out[1] = {16{8'h52}};
        b2b_in[2] = {16{8'h63}};           b2b_out[2] = '0;
        b2b_in[3] = {128{1'b1}};           b2b_out[3] = {16{8'h7d}};
        b2b_in[4] = {4{32'h16ed527c}};     b2b_out[4] = {4{32'hff534801}};
        for (int i = 0; i < 5; i++) begin
            send(0, b2b_in[i], b2b_out[i], 1'b1);
            e0 = cyc;
            probe(0, e0 + 4, 3'b011, 1'b1, b2b_out[i]);
            probe(0, e0 + 5, 3'b100, 1'b1, b2b_out[i]);
        end
        in_valid[0] = 1'b0;
        drain();
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
